// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline: load-use bubbles, branch flushes, data-memory waits, halt.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT    = 255,
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ID_instruction,
  input  logic [31:0] EX_instruction,
  input  logic        EX_mem_read,
  input  logic        EX_branch_taken,
  input  logic        MEM_mem_access,
  input  logic        dmem_ready,
  output logic        PC_write_enable,
  output logic        IF_ID_write_enable,
  output logic        ID_EX_write_enable,
  output logic        EX_MEM_write_enable,
  output logic        MEM_WB_write_enable,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        halted,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_CNT_WIDTH-1:0] stall_count,
  output logic [PERF_CNT_WIDTH-1:0] flush_count,
`endif
  output logic        error
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALT} state_t;

  state_t                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     err_q, err_d;

  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic [6:0] id_opc;
  logic       id_uses_rs2, load_use, is_system, resolve;

  assign ex_rd       = EX_instruction[11:7];
  assign id_rs1      = ID_instruction[19:15];
  assign id_rs2      = ID_instruction[24:20];
  assign id_opc      = ID_instruction[6:0];
  assign id_uses_rs2 = (id_opc == 7'b0110011) || (id_opc == 7'b0100011) || (id_opc == 7'b1100011);
  assign load_use    = EX_mem_read && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign is_system   = (id_opc == 7'b1110011) && (ID_instruction[14:12] == 3'b000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    err_d               = err_q;
    resolve             = 1'b0;
    PC_write_enable     = 1'b0;
    IF_ID_write_enable  = 1'b0;
    ID_EX_write_enable  = 1'b0;
    EX_MEM_write_enable = 1'b0;
    MEM_WB_write_enable = 1'b0;
    IF_ID_flush         = 1'b0;
    ID_EX_flush         = 1'b0;

    case (state_q)
      S_RUN: begin
        if (MEM_mem_access && !dmem_ready) begin
          state_d = S_MEM_WAIT;
          cnt_d   = TIMEOUT_WIDTH'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready) begin
          resolve = 1'b1;
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_WIDTH'(MEM_TIMEOUT)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      default: ;
    endcase

    // Branch outranks load-use: the flushed ID instruction makes the hazard moot.
    if (resolve) begin
      PC_write_enable     = 1'b1;
      IF_ID_write_enable  = 1'b1;
      ID_EX_write_enable  = 1'b1;
      EX_MEM_write_enable = 1'b1;
      MEM_WB_write_enable = 1'b1;
      if (EX_branch_taken) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (load_use) begin
        PC_write_enable    = 1'b0;
        IF_ID_write_enable = 1'b0;
        ID_EX_flush        = 1'b1;
      end else if (is_system) begin
        ID_EX_flush = 1'b1;
        state_d     = S_HALT;
      end
    end

    if (rst) begin
      PC_write_enable     = 1'b0;
      IF_ID_write_enable  = 1'b0;
      ID_EX_write_enable  = 1'b0;
      EX_MEM_write_enable = 1'b0;
      MEM_WB_write_enable = 1'b0;
      IF_ID_flush         = 1'b0;
      ID_EX_flush         = 1'b0;
    end
  end

  assign halted = (state_q == S_HALT) && !rst;
  assign error  = err_q && !rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (state_q != S_HALT) begin
      if (!PC_write_enable && (stall_q != '1)) stall_q <= stall_q + PERF_CNT_WIDTH'(1);
      if (IF_ID_flush && (flush_q != '1))      flush_q <= flush_q + PERF_CNT_WIDTH'(1);
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed plus randomized bench for pipeline_hazard_controller against a rule-level reference model.
module tb_pipeline_hazard_controller;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ID_instruction = 32'h13, EX_instruction = 32'h13;
  logic        EX_mem_read = 1'b0, EX_branch_taken = 1'b0, MEM_mem_access = 1'b0, dmem_ready = 1'b0;
  logic        PC_write_enable, IF_ID_write_enable, ID_EX_write_enable, EX_MEM_write_enable;
  logic        MEM_WB_write_enable, IF_ID_flush, ID_EX_flush, halted, error;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
  int          m_stall, m_flush;
`endif

  int errors = 0;
  int checks = 0;
  int m_wait;
  bit m_halt, m_err;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .TIMEOUT_WIDTH(8), .PERF_CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ID_instruction(ID_instruction), .EX_instruction(EX_instruction),
    .EX_mem_read(EX_mem_read), .EX_branch_taken(EX_branch_taken),
    .MEM_mem_access(MEM_mem_access), .dmem_ready(dmem_ready),
    .PC_write_enable(PC_write_enable), .IF_ID_write_enable(IF_ID_write_enable),
    .ID_EX_write_enable(ID_EX_write_enable), .EX_MEM_write_enable(EX_MEM_write_enable),
    .MEM_WB_write_enable(MEM_WB_write_enable), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .halted(halted),
`ifdef HAZARD_PERF_CNT_EN
    .stall_count(stall_count), .flush_count(flush_count),
`endif
    .error(error)
  );

  logic [8:0] obs;
  assign obs = {PC_write_enable, IF_ID_write_enable, ID_EX_write_enable, EX_MEM_write_enable,
                MEM_WB_write_enable, IF_ID_flush, ID_EX_flush, halted, error};

  function automatic bit exp_load_use(logic [31:0] idi, logic [31:0] exi, logic mr);
    int  rd, rs1, rs2;
    bit  two_src;
    rd  = int'(exi[11:7]);
    rs1 = int'(idi[19:15]);
    rs2 = int'(idi[24:20]);
    two_src = (idi[6:0] == 7'h33) || (idi[6:0] == 7'h23) || (idi[6:0] == 7'h63);
    return mr && rd != 0 && (rd == rs1 || (two_src && rd == rs2));
  endfunction

  function automatic bit exp_sys(logic [31:0] idi);
    return idi[6:0] == 7'h73 && idi[14:12] == 3'd0;
  endfunction

  // Expected output vector from the model state and the current inputs.
  function automatic logic [8:0] model_out();
    bit go;
    if (rst)    return 9'b0;
    if (m_halt) return {7'b0, 1'b1, m_err};
    go = (m_wait == 0) ? !(MEM_mem_access && !dmem_ready) : dmem_ready;
    if (!go) return 9'b0;
    if (EX_branch_taken) return 9'b11111_11_00;
    if (exp_load_use(ID_instruction, EX_instruction, EX_mem_read)) return 9'b00111_01_00;
    if (exp_sys(ID_instruction)) return 9'b11111_01_00;
    return 9'b11111_00_00;
  endfunction

  task automatic model_next();
    bit go, sys_halt;
    if (rst) begin
      m_wait = 0; m_halt = 0; m_err = 0;
      return;
    end
    if (m_halt) return;
    go = (m_wait == 0) ? !(MEM_mem_access && !dmem_ready) : dmem_ready;
    sys_halt = go && !EX_branch_taken && !exp_load_use(ID_instruction, EX_instruction, EX_mem_read)
               && exp_sys(ID_instruction);
    if (go) begin
      m_wait = 0;
      if (sys_halt) m_halt = 1;
    end else if (m_wait == 0) begin
      m_wait = 1;
    end else if (m_wait == TO) begin
      m_halt = 1; m_err = 1;
    end else begin
      m_wait++;
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [31:0] idi, input logic [31:0] exi,
                      input logic mr, input logic bt, input logic ma, input logic rdy);
    logic [8:0] exp;
    rst = r; ID_instruction = idi; EX_instruction = exi;
    EX_mem_read = mr; EX_branch_taken = bt; MEM_mem_access = ma; dmem_ready = rdy;
    #1;
    if (r) begin
      m_wait = 0; m_halt = 0; m_err = 0;
`ifdef HAZARD_PERF_CNT_EN
      m_stall = 0; m_flush = 0;
`endif
    end
    exp = model_out();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s outputs got=%b want=%b", tag, obs, exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert (stall_count === 32'(m_stall) && flush_count === 32'(m_flush)) else begin
      errors++;
      $error("FAIL %s perf got=%0d/%0d want=%0d/%0d", tag, stall_count, flush_count, m_stall, m_flush);
    end
    if (!r && !m_halt) begin
      if (!exp[8]) m_stall++;
      if (exp[3])  m_flush++;
    end
`endif
    model_next();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LW_X5 = 32'h0000_A283;
  localparam logic [31:0] LW_X0 = 32'h0000_A003;
  localparam logic [31:0] ADD   = 32'h0072_8333;
  localparam logic [31:0] ADDI  = 32'h0050_0313;
  localparam logic [31:0] SW    = 32'h0053_2023;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic [6:0] opc_tab [6] = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h37};

  initial begin
    logic [31:0] idr, exr;
    m_wait = 0; m_halt = 0; m_err = 0;
`ifdef HAZARD_PERF_CNT_EN
    m_stall = 0; m_flush = 0;
`endif
    step("reset",        1, NOP, NOP, 0, 0, 0, 0);
    step("run",          0, NOP, NOP, 0, 0, 0, 0);
    step("loaduse_rs1",  0, ADD, LW_X5, 1, 0, 0, 0);
    step("after_bubble", 0, ADD, NOP, 0, 0, 0, 0);
    step("addi_no_stall",0, ADDI, LW_X5, 1, 0, 0, 0);
    step("sw_rs2_stall", 0, SW, LW_X5, 1, 0, 0, 0);
    step("rd_x0",        0, {12'd0, 5'd0, 3'd0, 5'd6, 7'h33}, LW_X0, 1, 0, 0, 0);
    step("branch_lu",    0, ADD, LW_X5, 1, 1, 0, 0);
    step("mem_same_rdy", 0, NOP, NOP, 0, 0, 1, 1);
    step("mem_wait1",    0, NOP, NOP, 0, 0, 1, 0);
    step("mem_wait2",    0, NOP, NOP, 0, 1, 1, 0);
    step("mem_wait3",    0, NOP, NOP, 0, 1, 1, 0);
    step("mem_resume_br",0, NOP, NOP, 0, 1, 1, 1);
    step("run_again",    0, NOP, NOP, 0, 0, 0, 0);
    step("mid_reset",    0, NOP, NOP, 0, 0, 1, 0);
    step("rst_in_wait",  1, NOP, NOP, 0, 0, 1, 0);
    step("rst_release",  0, NOP, NOP, 0, 0, 0, 0);
    for (int i = 0; i < TO + 3; i++) step("timeout", 0, NOP, NOP, 0, 0, 1, 0);
    step("timeout_held", 0, NOP, NOP, 0, 0, 0, 1);
    step("rst_clr_err",  1, NOP, NOP, 0, 0, 0, 0);
    step("ecall",        0, ECALL, NOP, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("ecall_halt", 0, NOP, NOP, 0, 0, 1, 1);
    step("ecall_rst",    1, NOP, NOP, 0, 0, 0, 0);
    step("ecall_release",0, NOP, NOP, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      idr = $urandom;
      idr[6:0]   = opc_tab[$urandom_range(0, 5)];
      idr[19:15] = 5'($urandom_range(0, 7));
      idr[24:20] = 5'($urandom_range(0, 7));
      exr = $urandom;
      exr[11:7]  = 5'($urandom_range(0, 7));
      step("random", ($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 3) == 0),
           idr, exr, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) < 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
